// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO definitions: endpoint addresses, read FSM
// state encodings and the byte/bit-counter widths used by the streamer.
package fx2_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  localparam logic [1:0] FIFO_EP2 = 2'b00;
  localparam logic [1:0] FIFO_EP6 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_READ   = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/byte_serializer.sv
// Byte serializer: shifts bytes out MSB first, one bit per clock.
// Ports:
//   clk, reset_n  - clock, async active-low reset
//   hold_data     - byte waiting in the hold register
//   hold_full     - hold register contains a byte
//   load_c        - combinational: this edge takes hold_data into the shifter
//   data_out      - serial bit (0 when not valid)
//   data_valid    - data_out carries a real bit
//   underrun      - one-cycle pulse when the stream stops for lack of data
module byte_serializer
  import fx2_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BYTE_W-1:0] hold_data,
  input  logic              hold_full,
  output logic              load_c,
  output logic              data_out,
  output logic              data_valid,
  output logic              underrun
);

  logic [BYTE_W-1:0] shift;
  logic [CNT_W-1:0]  cnt;

  // cnt holds the number of bits still to follow the one on data_out,
  // so cnt==0 while the LSB is on the wire: chaining there is gapless.
  assign load_c = hold_full && (!data_valid || (cnt == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift      <= '0;
      cnt        <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (load_c) begin
        data_out   <= hold_data[BYTE_W-1];
        shift      <= {hold_data[BYTE_W-2:0], 1'b0};
        cnt        <= CNT_W'(BYTE_W - 1);
        data_valid <= 1'b1;
      end else if (data_valid && (cnt != '0)) begin
        data_out <= shift[BYTE_W-1];
        shift    <= {shift[BYTE_W-2:0], 1'b0};
        cnt      <= cnt - CNT_W'(1);
      end else if (data_valid) begin
        // LSB done and nothing buffered: stream stops.
        data_out   <= 1'b0;
        data_valid <= 1'b0;
        underrun   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_stream_out.sv
// Reads bytes from the FX2 EP2 slave FIFO and streams them out serially.
// Ports:
//   clk, reset_n        - clock, async active-low reset
//   en                  - allow new FX2 reads
//   flaga               - EP2 empty flag, active-low (1 = data available)
//   fdata               - FX2 data bus
//   clk_o               - forwarded interface clock (~clk)
//   faddr               - FIFO select (EP2)
//   sloe, slrd          - FX2 output enable / read strobe, active-low
//   slwr, pkt_end       - unused write-side strobes, held inactive
//   data_out            - serial stream, MSB first
//   data_valid          - data_out carries a real bit
//   underrun            - pulse when a running stream runs dry
module fifo_stream_out
  import fx2_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              flaga,
  input  logic [BYTE_W-1:0] fdata,
  output logic              clk_o,
  output logic [1:0]        faddr,
  output logic              sloe,
  output logic              slrd,
  output logic              slwr,
  output logic              pkt_end,
  output logic              data_out,
  output logic              data_valid,
  output logic              underrun
);

  fsm_state_t        state;
  logic              armed;
  logic [BYTE_W-1:0] hold;
  logic              hold_full;
  logic              load_c;

  assign clk_o   = ~clk;
  assign faddr   = FIFO_EP2;
  assign slwr    = 1'b1;
  assign pkt_end = 1'b1;

  // Read FSM; sloe/slrd are registered alongside the state they belong to.
  // armed blocks a SELECT on the first edge after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      sloe  <= 1'b1;
      slrd  <= 1'b1;
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (armed && en && flaga && !hold_full) begin
            state <= ST_SELECT;
            sloe  <= 1'b0;
            slrd  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            sloe  <= 1'b1;
            slrd  <= 1'b1;
          end
        end
        ST_SELECT: begin
          state <= ST_READ;
          sloe  <= 1'b0;
          slrd  <= 1'b0;
        end
        ST_READ: begin
          state <= ST_IDLE;
          sloe  <= 1'b1;
          slrd  <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          sloe  <= 1'b1;
          slrd  <= 1'b1;
        end
      endcase
    end
  end

  // Hold register: a capture at the READ closing edge wins over a
  // simultaneous load into the shifter, which still takes the old value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (state == ST_READ) begin
      hold      <= fdata;
      hold_full <= 1'b1;
    end else if (load_c) begin
      hold_full <= 1'b0;
    end
  end

  byte_serializer u_ser (
    .clk        (clk),
    .reset_n    (reset_n),
    .hold_data  (hold),
    .hold_full  (hold_full),
    .load_c     (load_c),
    .data_out   (data_out),
    .data_valid (data_valid),
    .underrun   (underrun)
  );

endmodule

// File: doc/fifo_stream_out.md
FIFO_STREAM_OUT -- requirements
Module: fifo_stream_out

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port en, input, 1, streaming enable; 0 means no new FX2 reads are issued.
REQ-004 SHALL have port flaga, input, 1, EP2 empty flag, active-low (1 = data available).
REQ-005 SHALL have port fdata, input, 8, FX2 slave-FIFO data bus (read-only in this block).
REQ-006 SHALL have port clk_o, output, 1, forwarded FX2 interface clock, equal to ~clk.
REQ-007 SHALL have port faddr, output, 2, FIFO select, constant EP2 address 2'b00.
REQ-008 SHALL have port sloe, output, 1, FX2 output enable, active-low.
REQ-009 SHALL have port slrd, output, 1, FX2 read strobe, active-low.
REQ-010 SHALL have port slwr, output, 1, tied inactive 1.
REQ-011 SHALL have port pkt_end, output, 1, tied inactive 1.
REQ-012 SHALL have port data_out, output, 1, serial bit stream, MSB first.
REQ-013 SHALL have port data_valid, output, 1, high while data_out carries a real bit.
REQ-014 SHALL have port underrun, output, 1, one-cycle pulse when a running stream stops for lack of data.

Function
REQ-015 SHALL implement read FSM states IDLE, SELECT, READ.
REQ-016 IDLE -> SELECT when en=1, flaga=1 and hold register empty; otherwise stay in IDLE.
REQ-017 SELECT: sloe=0, slrd=1, one cycle; the state then goes to READ unconditionally.
REQ-018 READ: sloe=0, slrd=0 for exactly one cycle; fdata captured into hold register at the closing edge; hold_full set; the state then goes to IDLE.
REQ-019 In IDLE, sloe=1 and slrd=1.
REQ-020 Minimum spacing is 3 cycles per byte read; flaga is never sampled in the cycle directly after READ, which covers flag latency.
REQ-021 Shift register loads from hold (clearing hold_full) when the serializer is idle, or on the edge emitting bit 0 (LSB) if hold_full=1; back-to-back bytes are therefore gapless.
REQ-022 The serializer emits bit 7 down to bit 0, one bit per cycle; data_valid=1 for all 8 cycles.
REQ-023 Latency from the READ closing edge to the first data_out bit with an idle serializer is 1 cycle.
REQ-024 If the LSB is emitted and hold_full=0, data_valid SHALL drop on the next cycle with data_out=0, and underrun SHALL pulse for that one cycle.
REQ-025 Simultaneous load-from-hold and READ capture in the same cycle: the shift load takes the old hold value and the capture refills hold. No byte is lost or duplicated.
REQ-026 en deasserted mid-stream: an in-flight SELECT/READ completes, and already buffered bytes (hold plus shift) are fully emitted; no further reads are issued.
REQ-027 At most 2 bytes SHALL be buffered (hold plus shift); a read is never issued while hold_full=1.

Reset
REQ-028 Asserting reset_n=0 at any time, including mid-read or mid-byte, SHALL immediately set: state IDLE, sloe=1, slrd=1, faddr=2'b00, data_out=0, data_valid=0, underrun=0, hold_full=0, bit counter=0; partial bytes are discarded.
REQ-029 After release, the first read SELECT SHALL occur no earlier than the second rising edge.

Structure
REQ-030 Shared package fx2_pkg SHALL hold the FIFO address constants (EP2=2'b00, EP6=2'b10), the FSM state encodings and the byte width 8.
REQ-031 The serializer (shift register, 3-bit bit counter, data_valid, underrun) SHALL be sub-module byte_serializer; the read FSM and hold register stay in fifo_stream_out.

Verification
REQ-032 Single byte: en=1, flaga=1 for one read, fdata=8'hA5 -> slrd low exactly one cycle; data_out 1,0,1,0,0,1,0,1 with data_valid=1 for 8 cycles; then underrun pulses once.
REQ-033 Back-to-back: flaga=1 held, fdata sequence 8'h3C, 8'hFF -> 16 contiguous valid bits 00111100 11111111; no underrun between the bytes; never more than one read pending while hold is full.
REQ-034 Empty FIFO: flaga=0, en=1 for 20 cycles -> sloe and slrd stay 1, data_valid=0.
REQ-035 Enable drop: en falls during bit 3 of byte 8'h81 with hold=8'h42 -> both bytes emitted fully, then no further slrd pulses.
REQ-036 Reset mid-byte: reset_n=0 asynchronously during bit 4 -> data_valid and data_out go 0 immediately, sloe and slrd go 1; after release with flaga=1, the stream restarts from a fresh byte.
